// File: rtl/dmem_arbiter.sv
// Two-port arbiter (CPU, debug/loader) in front of a single data-memory port.
// Burst-limited alternation, plus one memory-mapped 8-bit LED register.
module dmem_arbiter #(
  parameter logic [31:0] LED_ADDR  = 32'hFFFF_FF00,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_ack,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic [7:0]  led_reg
);

  localparam int unsigned CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    GNT_DBG = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic          last_dbg, last_dbg_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic          led_we;
  logic [7:0]    led_d;

  // Generic per-grant signals: "own" is the granted port, "oth" the other one.
  logic          own_req, own_we, oth_req, own_led;
  logic [31:0]   own_addr, own_wdata;
  state_t        oth_state;

  assign cnt_inc = (cnt >= MAXC) ? MAXC : cnt + 1'b1;

  always_comb begin
    own_req   = 1'b0;
    own_we    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    oth_req   = 1'b0;
    oth_state = IDLE;
    case (state)
      GNT_CPU: begin
        own_req   = cpu_req;
        own_we    = cpu_we;
        own_addr  = cpu_addr;
        own_wdata = cpu_wdata;
        oth_req   = dbg_req;
        oth_state = GNT_DBG;
      end
      GNT_DBG: begin
        own_req   = dbg_req;
        own_we    = dbg_we;
        own_addr  = dbg_addr;
        own_wdata = dbg_wdata;
        oth_req   = cpu_req;
        oth_state = GNT_CPU;
      end
      default: ;
    endcase
  end

  assign own_led = (own_addr == LED_ADDR);

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    last_dbg_nx = last_dbg;
    cpu_ack     = 1'b0;
    dbg_ack     = 1'b0;
    cpu_rdata   = '0;
    dbg_rdata   = '0;
    mem_we      = 1'b0;
    mem_a       = '0;
    mem_wd      = '0;
    led_we      = 1'b0;
    led_d       = led_reg;

    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (cpu_req && dbg_req) state_nx = last_dbg ? GNT_CPU : GNT_DBG;
        else if (cpu_req)       state_nx = GNT_CPU;
        else if (dbg_req)       state_nx = GNT_DBG;
      end
      GNT_CPU, GNT_DBG: begin
        mem_a  = own_addr;
        mem_wd = own_wdata;
        mem_we = own_req & own_we & ~own_led;
        led_we = own_req & own_we & own_led;
        led_d  = own_wdata[7:0];
        if (state == GNT_CPU) begin
          cpu_ack   = cpu_req;
          cpu_rdata = own_led ? {24'b0, led_reg} : mem_rd;
        end else begin
          dbg_ack   = dbg_req;
          dbg_rdata = own_led ? {24'b0, led_reg} : mem_rd;
        end
        // Counter saturates at MAXC, so a late request from the other
        // port still forces a switch after exactly one more access.
        if (!own_req) begin
          cnt_nx   = '0;
          state_nx = oth_req ? oth_state : IDLE;
        end else if (cnt_inc == MAXC && oth_req) begin
          cnt_nx   = '0;
          state_nx = oth_state;
        end else begin
          cnt_nx   = cnt_inc;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase

    if (state_nx == GNT_CPU)      last_dbg_nx = 1'b0;
    else if (state_nx == GNT_DBG) last_dbg_nx = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      last_dbg <= 1'b1;
      led_reg  <= 8'h00;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      last_dbg <= last_dbg_nx;
      if (led_we) led_reg <= led_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [31:0] cpu_rdata, dbg_rdata, mem_a, mem_wd, mem_rd;
  logic        cpu_ack, dbg_ack, mem_we;
  logic [7:0]  led_reg;

  logic [31:0] mem [0:63];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.LED_ADDR(32'hFFFF_FF00), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .led_reg(led_reg)
  );

  assign mem_rd = mem[mem_a[5:0]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_a[5:0]] = mem_wd;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[6'h10] = 32'hDEAD_BEEF;
    mem[6'h11] = 32'h1111_1111;

    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    #2;
    check("rst_cpu_ack", {31'b0, cpu_ack}, 32'd0);
    check("rst_dbg_ack", {31'b0, dbg_ack}, 32'd0);
    check("rst_mem_we",  {31'b0, mem_we},  32'd0);
    check("rst_led",     {24'b0, led_reg}, 32'h00);

    // CPU read of 0x10 requested across reset release
    cpu_req = 1'b1; cpu_addr = 32'h10;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    check("idle_no_ack", {31'b0, cpu_ack}, 32'd0);
    tick;
    check("rd_cpu_ack",   {31'b0, cpu_ack}, 32'd1);
    check("rd_cpu_rdata", cpu_rdata,        32'hDEAD_BEEF);
    check("rd_mem_we",    {31'b0, mem_we},  32'd0);
    check("rd_dbg_ack",   {31'b0, dbg_ack}, 32'd0);
    check("rd_dbg_rdata", dbg_rdata,        32'd0);

    // CPU drops with DBG idle -> IDLE; then tie goes to DBG
    cpu_req = 1'b0;
    tick;
    check("idle_mem_a", mem_a, 32'd0);
    cpu_req = 1'b1; dbg_req = 1'b1; dbg_addr = 32'h11;
    tick;
    check("tie_dbg_rdata", dbg_rdata, 32'h1111_1111);
    check("tie_cpu_rdata", cpu_rdata, 32'd0);

    // Both held: DBG x4, CPU x4, DBG x4
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick;
      check($sformatf("burst%0d_dbg", i), {31'b0, dbg_ack}, (i < 4 || i >= 8) ? 32'd1 : 32'd0);
      check($sformatf("burst%0d_cpu", i), {31'b0, cpu_ack}, (i >= 4 && i < 8) ? 32'd1 : 32'd0);
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick;
    check("idle2_ack", {30'b0, cpu_ack, dbg_ack}, 32'd0);

    // Debug write to LED register
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'hFFFF_FF00; dbg_wdata = 32'h0000_00A5;
    tick;
    check("led_dbg_ack", {31'b0, dbg_ack}, 32'd1);
    check("led_mem_we",  {31'b0, mem_we},  32'd0);
    check("led_before",  {24'b0, led_reg}, 32'h00);
    tick;
    check("led_after",   {24'b0, led_reg}, 32'hA5);
    dbg_req = 1'b0; dbg_we = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hFFFF_FF00;
    tick;
    check("led_cpu_ack",   {31'b0, cpu_ack}, 32'd1);
    check("led_cpu_rdata", cpu_rdata,        32'h0000_00A5);

    // Plain memory write then same-cycle read-back
    cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h1234_5678;
    #1;
    check("wr_mem_we", {31'b0, mem_we}, 32'd1);
    check("wr_mem_a",  mem_a,           32'h20);
    check("wr_mem_wd", mem_wd,          32'h1234_5678);
    tick;
    cpu_we = 1'b0;
    #1;
    check("wr_readback", cpu_rdata, 32'h1234_5678);

    // CPU alone saturates the counter; late DBG request gets one more CPU ack
    for (int i = 0; i < 10; i++) tick;
    check("sat_cpu_ack", {31'b0, cpu_ack}, 32'd1);
    dbg_req = 1'b1; dbg_addr = 32'h11;
    #1;
    check("sat_last_cpu", {31'b0, cpu_ack}, 32'd1);
    check("sat_no_dbg",   {31'b0, dbg_ack}, 32'd0);
    tick;
    check("sat_sw_dbg", {31'b0, dbg_ack}, 32'd1);
    check("sat_sw_cpu", {31'b0, cpu_ack}, 32'd0);
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick;

    // Asynchronous reset mid-write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hCAFE_F00D;
    tick;
    check("ar_mem_we_pre", {31'b0, mem_we},  32'd1);
    check("ar_ack_pre",    {31'b0, cpu_ack}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_mem_we", {31'b0, mem_we},  32'd0);
    check("ar_ack",    {31'b0, cpu_ack}, 32'd0);
    check("ar_led",    {24'b0, led_reg}, 32'h00);
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 32'h10; dbg_req = 1'b1; dbg_addr = 32'h11;
    @(negedge clk);
    check("ar_mem_kept", mem[6'h20], 32'h1234_5678);
    reset = 1'b1;
    tick;
    check("ar_tie_cpu", {31'b0, cpu_ack}, 32'd1);
    check("ar_tie_dbg", {31'b0, dbg_ack}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
